// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Drives the four minterms of a 2-input gate under test, samples its output
//   after a settle time per minterm, and reports the captured truth table and a
//   pass/fail verdict against EXPECTED.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request a sweep (accepted only when idle)
//   s_in              output of the gate under test
//   a_out, b_out      gate inputs, a = m[1], b = m[0]
//   busy              high while minterms are being driven/sampled
//   done              one-cycle completion pulse
//   pass              no mismatches in the last sweep
//   result, err_mask  captured s_in per minterm, and mismatch per minterm
module gate_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [3:0] err_mask
);

  localparam int unsigned CNT_W = 8;
  // A settle time of zero still needs one cycle for the gate to respond.
  localparam int unsigned S_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(S_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       result_q, result_d;
  logic [3:0]       err_q, err_d;

  // An unknown or floating gate output captures as 0 and always counts as a mismatch.
  logic s_one_c;
  logic s_known_c;
  assign s_one_c   = (s_in === 1'b1);
  assign s_known_c = (s_in === 1'b0) || (s_in === 1'b1);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    pass_d   = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          m_d      = 2'd0;
          cnt_d    = CNT_LOAD;
          result_d = 4'b0000;
          err_d    = 4'b0000;
          pass_d   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        result_d[m_q] = s_one_c;
        err_d[m_q]    = !s_known_c || (s_one_c != EXPECTED[m_q]);
        if (m_q == 2'd3) begin
          state_d = ST_DONE;
          // Verdict must be visible in the same cycle as done.
          pass_d  = (err_d == 4'b0000);
        end else begin
          state_d = ST_SETTLE;
          m_d     = m_q + 2'd1;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered off the next state so they line up with state_q.
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    a_d    = busy_d & m_d[1];
    b_d    = busy_d & m_d[0];
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      m_q      <= 2'd0;
      cnt_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= 4'b0000;
      err_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign result   = result_q;
  assign err_mask = err_q;

endmodule
